// File: rtl/oddr_gearx_pkg.sv
// Shared definitions for the ODDR gearbox serializer: FSM states, legal
// gearing ratios and small elaboration-time helpers.
package oddr_gearx_pkg;

   // Serializer sequencing states.
   typedef enum logic [1:0] {
      StIdle,
      StPre,
      StShift
   } gear_state_e;

   // Bit g set means a gearing ratio of g slots per word is supported (2, 4, 8).
   localparam int unsigned GearLegalMask = 32'h0000_0114;

   // Preamble length bounds; the preamble counter is sized for PreLenMax.
   localparam int unsigned PreLenMin = 1;
   localparam int unsigned PreLenMax = 15;
   localparam int unsigned PreCntW   = 4;

   // True when the requested gearing ratio is supported.
   function automatic bit gear_is_legal(input int unsigned gear);
      return ((GearLegalMask >> gear) & 32'd1) != 32'd0;
   endfunction

   // True when the preamble length fits the counter.
   function automatic bit pre_len_is_legal(input int unsigned pre_len);
      return (pre_len >= PreLenMin) && (pre_len <= PreLenMax);
   endfunction

   // Width of the slot index; never below one bit so the counter always exists.
   function automatic int unsigned slot_width(input int unsigned gear);
      return (gear <= 2) ? 1 : $clog2(gear);
   endfunction

endpackage

// File: rtl/oddr_gear_slotmux.sv
// Slot selector: picks the LANES bits of one slot out of a parallel word.
// Slot s of lane l lives at word bit s*LANES+l.
module oddr_gear_slotmux
   import oddr_gearx_pkg::*;
#(
   parameter int unsigned LANES = 1,
   parameter int unsigned GEAR  = 4,
   parameter int unsigned SlotW = slot_width(GEAR)
) (
   input  logic [LANES*GEAR-1:0] word_i,
   input  logic [SlotW-1:0]      slot_i,
   output logic [LANES-1:0]      lanes_o
);

   // Decode the slot index into a lane-wide slice of the word.
   always_comb begin
      lanes_o = '0;
      for (int s = 0; s < int'(GEAR); s++) begin
         if (slot_i == SlotW'(s)) begin
            lanes_o = word_i[s*LANES +: LANES];
         end
      end
   end

endmodule

// File: rtl/oddr_gearx.sv
// Parallel-to-serial output gearbox. A two-deep word buffer (holding register
// feeding a shift register) lets consecutive words stream out with no gap.
// An optional all-zero preamble precedes each burst.
module oddr_gearx
   import oddr_gearx_pkg::*;
#(
   parameter int unsigned LANES    = 1,
   parameter int unsigned GEAR     = 4,
   parameter string       MEMMODE  = "DISABLED",
   parameter int unsigned PRE_LEN  = 2,
   parameter logic        IDLE_VAL = 1'b0
) (
   input  logic                  SCLK,
   input  logic                  RST_N,
   input  logic [LANES*GEAR-1:0] DA,
   input  logic                  DVALID,
   output logic                  DREADY,
   output logic [LANES-1:0]      Q,
   output logic                  QOE,
   output logic                  BURST_END
);

   localparam int unsigned W     = LANES * GEAR;
   localparam int unsigned SlotW = slot_width(GEAR);
   localparam bit          PreEn = (MEMMODE == "ENABLED");

   // Reject unsupported configurations while elaborating.
   if (!gear_is_legal(GEAR)) begin : g_bad_gear
      $error("oddr_gearx: GEAR must be 2, 4 or 8");
   end
   if (!pre_len_is_legal(PRE_LEN)) begin : g_bad_pre_len
      $error("oddr_gearx: PRE_LEN must be in 1..15");
   end
   if ((MEMMODE != "ENABLED") && (MEMMODE != "DISABLED")) begin : g_bad_memmode
      $error("oddr_gearx: MEMMODE must be \"ENABLED\" or \"DISABLED\"");
   end
   if (LANES < 1) begin : g_bad_lanes
      $error("oddr_gearx: LANES must be at least 1");
   end

   gear_state_e          state_q, state_d;
   logic [W-1:0]         hold_q, hold_d;
   logic                 hold_vld_q, hold_vld_d;
   logic [W-1:0]         shift_q, shift_d;
   logic [SlotW-1:0]     slot_q, slot_d;
   logic [PreCntW-1:0]   pre_cnt_q, pre_cnt_d;
   logic                 rdy_en_q;

   logic                 last_slot;
   logic                 hold_move;
   logic                 accept;
   logic                 burst_end;
   logic [LANES-1:0]     slot_bits;

   assign last_slot = (slot_q == SlotW'(GEAR - 1));

   // The held word moves into the shift register when a burst starts or when
   // the current word is on its final slot.
   assign hold_move = hold_vld_q &&
                      ((state_q == StIdle) || ((state_q == StShift) && last_slot));

   // rdy_en_q keeps DREADY low until the first edge out of reset.
   assign DREADY = rdy_en_q && (!hold_vld_q || hold_move);
   assign accept = DVALID && DREADY;

   oddr_gear_slotmux #(
      .LANES (LANES),
      .GEAR  (GEAR),
      .SlotW (SlotW)
   ) u_slotmux (
      .word_i  (shift_q),
      .slot_i  (slot_q),
      .lanes_o (slot_bits)
   );

   // Holding register: a drain and a refill in the same cycle keeps it full.
   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (hold_move) begin
         hold_vld_d = 1'b0;
      end
      if (accept) begin
         hold_d     = DA;
         hold_vld_d = 1'b1;
      end
   end

   // Sequencer next state: burst start, preamble count and slot stepping.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      slot_d    = slot_q;
      pre_cnt_d = pre_cnt_q;
      burst_end = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hold_vld_q) begin
               shift_d   = hold_q;
               slot_d    = '0;
               pre_cnt_d = '0;
               state_d   = PreEn ? StPre : StShift;
            end
         end
         StPre: begin
            if (pre_cnt_q == PreCntW'(PRE_LEN - 1)) begin
               state_d = StShift;
            end else begin
               pre_cnt_d = pre_cnt_q + 1'b1;
            end
         end
         StShift: begin
            if (last_slot) begin
               slot_d = '0;
               if (hold_vld_q) begin
                  // Chain straight into the next word, no preamble.
                  shift_d = hold_q;
               end else begin
                  burst_end = 1'b1;
                  state_d   = StIdle;
               end
            end else begin
               slot_d = slot_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output drive follows the current state.
   always_comb begin
      Q   = {LANES{IDLE_VAL}};
      QOE = 1'b0;
      unique case (state_q)
         StIdle: begin
            Q   = {LANES{IDLE_VAL}};
            QOE = 1'b0;
         end
         StPre: begin
            Q   = '0;
            QOE = 1'b1;
         end
         StShift: begin
            Q   = slot_bits;
            QOE = 1'b1;
         end
         default: begin
            Q   = {LANES{IDLE_VAL}};
            QOE = 1'b0;
         end
      endcase
   end

   assign BURST_END = burst_end;

   // State registers with synchronous active-low reset; reset drops all data.
   always_ff @(posedge SCLK) begin
      if (!RST_N) begin
         state_q    <= StIdle;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         shift_q    <= '0;
         slot_q     <= '0;
         pre_cnt_q  <= '0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         shift_q    <= shift_d;
         slot_q     <= slot_d;
         pre_cnt_q  <= pre_cnt_d;
         rdy_en_q   <= 1'b1;
      end
   end

endmodule

// File: doc/oddr_gearx.md
ODDR_GEARX -- requirements
Module: oddr_gearx

Interface
REQ-001 The block SHALL have parameter LANES, default 1, meaning the number of independent serial output lanes.
REQ-002 The block SHALL have parameter GEAR, default 4, meaning slots per parallel word; legal values are 2, 4 and 8.
REQ-003 The block SHALL have parameter MEMMODE, default "DISABLED", meaning preamble insertion is off; "ENABLED" turns it on.
REQ-004 The block SHALL have parameter PRE_LEN, default 2, meaning preamble length in cycles (1..15), used only when MEMMODE="ENABLED".
REQ-005 The block SHALL have parameter IDLE_VAL, default 1'b0, meaning the per-lane value driven on Q when no burst is active.
REQ-006 Ports SHALL be:
  SCLK    input   1             sole clock; all logic on its rising edge
  RST_N   input   1             synchronous, active-low reset
  DA      input   LANES*GEAR    parallel word; slot s of lane l = DA[s*LANES+l]
  DVALID  input   1             DA holds a valid word
  DREADY  output  1             block accepts DA this cycle
  Q       output  LANES         serial output, one slot per cycle
  QOE     output  1             high while a preamble or data slot is on Q
  BURST_END output 1            one-cycle pulse on the last data slot of a burst

Function
REQ-007 A word SHALL be transferred on a rising edge where DVALID=1 and DREADY=1; DA is ignored otherwise.
REQ-008 The block SHALL hold one word in a holding register and one in a shift register, giving two words of storage.
REQ-009 DREADY SHALL be high when the holding register is empty, or when it is being moved into the shift register in the same cycle.
REQ-010 The FSM SHALL have three states:
  - IDLE: Q=IDLE_VAL, QOE=0.
  - PRE: Q=all-zero, QOE=1, counts PRE_LEN cycles.
  - SHIFT: Q=current slot, QOE=1.
REQ-011 From IDLE with a word available, the FSM SHALL go to PRE when MEMMODE="ENABLED", otherwise directly to SHIFT.
REQ-012 Slot 0 SHALL be output first, then slots 1..GEAR-1 in order, one per cycle, using a slot counter of width clog2(GEAR).
REQ-013 Latency: with MEMMODE="DISABLED", a word accepted at edge t while IDLE SHALL drive slot 0 on Q from edge t+1.
REQ-014 Latency: with MEMMODE="ENABLED", the preamble SHALL occupy edges t+1..t+PRE_LEN and slot 0 SHALL follow at edge t+PRE_LEN+1.
REQ-015 At slot GEAR-1, if a word is held, it SHALL load into the shift register and slot 0 SHALL follow with no gap and no new preamble.
REQ-016 At slot GEAR-1, if no word is held, BURST_END SHALL pulse during that slot and the FSM SHALL return to IDLE on the next edge.
REQ-017 Transfers accepted during PRE SHALL be buffered (up to two words) and SHALL NOT restart the preamble.
REQ-018 Words SHALL never be dropped, duplicated or reordered; DREADY=0 whenever both storage registers are full.
REQ-019 When the holding register is drained and refilled in the same cycle, the new word SHALL be accepted, with DREADY remaining 1.

Reset
REQ-020 While RST_N=0 at a rising edge, the block SHALL set: FSM=IDLE, both registers empty, counters=0, Q=IDLE_VAL, QOE=0, DREADY=0, BURST_END=0.
REQ-021 DREADY SHALL go high on the first edge after RST_N returns to 1.
REQ-022 A reset asserted mid-burst SHALL discard all buffered data and SHALL NOT pulse BURST_END.

Structure
REQ-023 The FSM state enum and the legal-GEAR check constant SHALL live in the shared ecp3 gearing package.
REQ-024 Slot selection SHALL be a sub-module oddr_gear_slotmux (word plus slot index to LANES bits); everything else stays in oddr_gearx.
REQ-025 An illegal GEAR or PRE_LEN SHALL cause an elaboration-time error.

Verification
REQ-026 LANES=1, GEAR=4, MEMMODE=DISABLED, single word DA=4'b1011 -> Q=1,1,0,1 on edges t+1..t+4; QOE high for exactly 4 cycles; BURST_END at t+4.
REQ-027 GEAR=4, three words 0xA, 0x5, 0xF sent back-to-back with DVALID held -> 12 contiguous slots, one BURST_END on the last slot, no QOE gap.
REQ-028 MEMMODE=ENABLED, PRE_LEN=2, DA=4'b1111 -> Q=0,0 with QOE=1, then 1,1,1,1; total QOE=6 cycles.
REQ-029 LANES=2, GEAR=8, DVALID held while the sink stalls -> DREADY drops after 2 words are stored; output order matches input order across 5 words.
REQ-030 RST_N=0 at slot 2 of a burst -> next edge gives Q=IDLE_VAL, QOE=0, no BURST_END; a fresh word afterwards serialises normally.
